// File: rtl/serv_shift_pw.sv
// Bit-serial shifter/rotator: buffers a W-bit operand streamed LSB-first,
// then streams the shifted/rotated result LSB-first, with an optional half-width sign-extending mode.
module serv_shift_pw #(
  parameter int W = 32,
  localparam int SW = $clog2(W)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_start,
  input  logic [2:0]    i_mode,
  input  logic          i_half,
  input  logic [SW-1:0] i_shamt,
  input  logic          i_d,
  output logic          o_busy,
  output logic          o_q,
  output logic          o_q_valid,
  output logic          o_done
);

  localparam int HN = W / 2;

  localparam logic [2:0] M_SLL = 3'b000;
  localparam logic [2:0] M_SRL = 3'b001;
  localparam logic [2:0] M_SRA = 3'b011;
  localparam logic [2:0] M_ROL = 3'b100;
  localparam logic [2:0] M_ROR = 3'b101;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_OUT} state_e;

  state_e        state_q, state_d;
  logic [SW-1:0] cnt_q, cnt_d;
  logic [2:0]    mode_q, mode_d;
  logic          half_q, half_d;
  logic [SW-1:0] shamt_q, shamt_d;
  logic [W-1:0]  buf_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    half_d  = half_q;
    shamt_d = shamt_q;
    case (state_q)
      S_IDLE: if (i_start) begin
        state_d = S_LOAD;
        cnt_d   = '0;
        mode_d  = i_mode;
        half_d  = i_half;
        // Half mode can only shift by 0..W/2-1, so drop the top amount bit.
        shamt_d = i_half ? (i_shamt & SW'(HN - 1)) : i_shamt;
      end
      S_LOAD: begin
        cnt_d = cnt_q + 1'b1;
        if (&cnt_q) begin
          state_d = S_OUT;
          cnt_d   = '0;
        end
      end
      S_OUT: begin
        cnt_d = cnt_q + 1'b1;
        if (&cnt_q) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mode_q  <= '0;
      half_q  <= 1'b0;
      shamt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      half_q  <= half_d;
      shamt_q <= shamt_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (state_q == S_LOAD) buf_q[cnt_q] <= i_d;
  end

  // Result bit select; indices carry one extra bit so k-s underflow and k+s overflow are visible.
  logic [SW:0]   k, s, n, idx_l, idx_r;
  logic [SW-1:0] msk;
  logic          msb, res_bit;

  always_comb begin
    // Upper half in half mode repeats result bit HN-1 (sign extension).
    k     = (half_q && cnt_q[SW-1]) ? (SW+1)'(HN - 1) : {1'b0, cnt_q};
    s     = {1'b0, shamt_q};
    n     = half_q ? (SW+1)'(HN) : (SW+1)'(W);
    msk   = half_q ? SW'(HN - 1) : SW'(W - 1);
    msb   = half_q ? buf_q[HN-1] : buf_q[W-1];
    idx_l = k - s;
    idx_r = k + s;
    res_bit = 1'b0;
    case (mode_q)
      M_SLL:   res_bit = (k >= s) ? buf_q[idx_l[SW-1:0]] : 1'b0;
      M_SRL:   res_bit = (idx_r < n) ? buf_q[idx_r[SW-1:0]] : 1'b0;
      M_SRA:   res_bit = (idx_r < n) ? buf_q[idx_r[SW-1:0]] : msb;
      M_ROL:   res_bit = buf_q[idx_l[SW-1:0] & msk];
      M_ROR:   res_bit = buf_q[idx_r[SW-1:0] & msk];
      default: res_bit = 1'b0;
    endcase
  end

  assign o_busy    = (state_q != S_IDLE);
  assign o_q_valid = (state_q == S_OUT);
  assign o_q       = o_q_valid & res_bit;
  assign o_done    = o_q_valid & (&cnt_q);

endmodule

// File: tb/tb_serv_shift_pw.sv
// Directed bench for serv_shift_pw (W=32): streams operands, collects result streams,
// and checks results plus handshake timing against hand-computed values.
module tb_serv_shift_pw;

  localparam int W = 32;

  logic       i_clk = 1'b0;
  logic       i_rst_n, i_start, i_half, i_d;
  logic [2:0] i_mode;
  logic [4:0] i_shamt;
  logic       o_busy, o_q, o_q_valid, o_done;

  int checks = 0;
  int errors = 0;

  serv_shift_pw #(.W(W)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_mode(i_mode),
    .i_half(i_half), .i_shamt(i_shamt), .i_d(i_d), .o_busy(o_busy),
    .o_q(o_q), .o_q_valid(o_q_valid), .o_done(o_done)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Entered at a negedge with the DUT idle; returns at the negedge of the idle cycle after o_done.
  task automatic run_op(input string tag, input logic [2:0] mode, input logic half,
                        input logic [4:0] sh, input logic [31:0] opnd, input logic [31:0] exp,
                        input bit hold, input bit midpulse);
    logic [31:0] res;
    logic        load_ok, valid_ok;
    int          done_cnt, done_k;
    i_start = 1'b1; i_mode = mode; i_half = half; i_shamt = sh;
    @(posedge i_clk); #1;
    if (!hold) i_start = 1'b0;
    // Config inputs are free to change once the op is accepted.
    i_mode = ~mode; i_half = ~half; i_shamt = ~sh;
    load_ok = 1'b1;
    for (int i = 0; i < W; i++) begin
      i_d = opnd[i];
      if (midpulse) i_start = (i == 10);
      @(negedge i_clk);
      if (!(o_busy === 1'b1 && o_q_valid === 1'b0 && o_done === 1'b0)) load_ok = 1'b0;
      @(posedge i_clk); #1;
    end
    i_d = 1'($urandom);
    res = '0; valid_ok = 1'b1; done_cnt = 0; done_k = -1;
    for (int k = 0; k < W; k++) begin
      @(negedge i_clk);
      if (!(o_q_valid === 1'b1 && o_busy === 1'b1)) valid_ok = 1'b0;
      res[k] = o_q;
      if (o_done === 1'b1) begin done_cnt++; done_k = k; end
      if (k == W - 1) i_start = hold ? 1'b1 : 1'b0;
      @(posedge i_clk); #1;
    end
    check({tag, " load"}, 32'(load_ok), 32'd1);
    check({tag, " valid"}, 32'(valid_ok), 32'd1);
    check({tag, " result"}, res, exp);
    check({tag, " done_at"}, 32'(done_k), 32'(W - 1));
    check({tag, " done_cnt"}, 32'(done_cnt), 32'd1);
    @(negedge i_clk);
    check({tag, " idle"}, {29'd0, o_busy, o_q_valid, o_done}, 32'd0);
  endtask

  initial begin
    i_rst_n = 1'b0; i_start = 1'b0; i_mode = 3'b000; i_half = 1'b0; i_shamt = '0; i_d = 1'b0;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    check("reset outs", {28'd0, o_busy, o_q, o_q_valid, o_done}, 32'd0);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    run_op("sll4",    3'b000, 1'b0, 5'd4,  32'h8000000F, 32'h000000F0, 0, 0);
    run_op("sra31",   3'b011, 1'b0, 5'd31, 32'h80000000, 32'hFFFFFFFF, 0, 0);
    run_op("srl31",   3'b001, 1'b0, 5'd31, 32'h80000000, 32'h00000001, 0, 0);
    run_op("ror8",    3'b101, 1'b0, 5'd8,  32'h12345678, 32'h78123456, 0, 0);
    run_op("rol0",    3'b100, 1'b0, 5'd0,  32'h12345678, 32'h12345678, 0, 0);
    run_op("rol4",    3'b100, 1'b0, 5'd4,  32'h12345678, 32'h23456781, 0, 0);
    run_op("sll0",    3'b000, 1'b0, 5'd0,  32'hDEADBEEF, 32'hDEADBEEF, 0, 0);
    run_op("sra4",    3'b011, 1'b0, 5'd4,  32'h7000_0000, 32'h0700_0000, 0, 0);
    run_op("hsll31",  3'b000, 1'b1, 5'd31, 32'hFFFF0001, 32'hFFFF8000, 0, 0);
    run_op("hsrl1",   3'b001, 1'b1, 5'd1,  32'h00008000, 32'h00004000, 0, 0);
    run_op("hsra4",   3'b011, 1'b1, 5'd4,  32'h0000F000, 32'hFFFFFF00, 0, 0);
    run_op("hror4",   3'b101, 1'b1, 5'd4,  32'hABCD1234, 32'h00004123, 0, 0);
    run_op("hrol1",   3'b100, 1'b1, 5'd1,  32'h00004000, 32'hFFFF8000, 0, 0);
    run_op("rsvd111", 3'b111, 1'b0, 5'd3,  32'hFFFFFFFF, 32'h00000000, 0, 0);
    run_op("midpulse",3'b001, 1'b0, 5'd4,  32'h0000ABCD, 32'h00000ABC, 0, 1);

    // Back-to-back with i_start held: second op's T0 is the edge right after the idle cycle.
    run_op("b2b_a",   3'b000, 1'b0, 5'd1,  32'h00000001, 32'h00000002, 1, 0);
    run_op("b2b_b",   3'b101, 1'b0, 5'd4,  32'h0000000F, 32'hF0000000, 0, 0);

    // Reset during OUT at bit 10.
    i_start = 1'b1; i_mode = 3'b000; i_half = 1'b0; i_shamt = 5'd0;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    for (int i = 0; i < W + 10; i++) begin
      i_d = 1'b1;
      @(posedge i_clk); #1;
    end
    @(negedge i_clk);
    check("pre-rst bit10", {30'd0, o_q_valid, o_done}, 32'd2);
    i_rst_n = 1'b0;
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    @(negedge i_clk);
    check("rst mid-out", {29'd0, o_busy, o_q_valid, o_done}, 32'd0);
    run_op("post-rst", 3'b001, 1'b0, 5'd16, 32'hCAFE0000, 32'h0000CAFE, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
